// File: rtl/bench_seq_misr_if.sv
// =============================================================================
// bench_seq_misr_if : control/data bundle for the bench_seq_misr core
// Revision: 1.0
// =============================================================================
`default_nettype none

interface bench_seq_misr_if #(
    parameter int IN_W    = 9,
    parameter int STATE_W = 15,
    parameter int OUT_W   = 11,
    parameter int CNT_W   = 8
);
    logic               start;
    logic               load;
    logic [STATE_W-1:0] load_val;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   run_len;
    logic [IN_W-1:0]    in;
    logic [OUT_W-1:0]   out;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] signature;
    logic               trig_hit;

    modport master (
        output start, load, load_val, mode, run_len, in,
        input  out, busy, done, signature, trig_hit
    );

    modport slave (
        input  start, load, load_val, mode, run_len, in,
        output out, busy, done, signature, trig_hit
    );
endinterface

`default_nettype wire

// File: rtl/bench_seq_misr.sv
// =============================================================================
// bench_seq_misr : run-length framed state register (HOLD/XOR/MISR/ROT update)
// Optional trigger monitor: define BENCH_SEQ_TRIG_MON_EN. Revision: 1.0
// =============================================================================
`default_nettype none

module bench_seq_misr #(
    parameter int                 IN_W     = 9,
    parameter int                 STATE_W  = 15,
    parameter int                 OUT_W    = 11,
    parameter int                 CNT_W    = 8,
    parameter logic [STATE_W-1:0] POLY     = STATE_W'('h0003),
    parameter logic [STATE_W-1:0] TRIG_VAL = STATE_W'('h01FE)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    bench_seq_misr_if.slave   bus
);

    localparam logic [1:0] c_mode_hold = 2'b00;
    localparam logic [1:0] c_mode_xor  = 2'b01;
    localparam logic [1:0] c_mode_misr = 2'b10;
    localparam logic [1:0] c_mode_rot  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    generate
        if (STATE_W < 2) begin : g_chk_state_w
            $error("bench_seq_misr: STATE_W must be >= 2");
        end
        if (OUT_W > STATE_W) begin : g_chk_out_w
            $error("bench_seq_misr: OUT_W must be <= STATE_W");
        end
    endgenerate

    state_t             r_fsm;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_sig;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_mode;
    logic               r_busy;
    logic               r_done;

    logic [STATE_W-1:0] w_inx;
    logic [STATE_W-1:0] w_upd;
    logic [STATE_W-1:0] w_state_d;

    generate
        if (IN_W >= STATE_W) begin : g_in_trunc
            assign w_inx = bus.in[STATE_W-1:0];
            if (IN_W > STATE_W) begin : g_in_drop
                logic w_unused_in_hi;
                assign w_unused_in_hi = ^bus.in[IN_W-1:STATE_W];
            end
        end else begin : g_in_ext
            assign w_inx = {{(STATE_W-IN_W){1'b0}}, bus.in};
        end
    endgenerate

    always_comb begin
        w_upd = r_state;
        case (r_mode)
            c_mode_hold: w_upd = r_state;
            c_mode_xor:  w_upd = r_state ^ w_inx;
            c_mode_misr: w_upd = {r_state[STATE_W-2:0], 1'b0}
                                 ^ (r_state[STATE_W-1] ? POLY : '0) ^ w_inx;
            c_mode_rot:  w_upd = {r_state[STATE_W-2:0], r_state[STATE_W-1]} ^ w_inx;
            default:     w_upd = r_state;
        endcase
    end

    // Single next-state view shared by the register and the trigger monitor.
    always_comb begin
        w_state_d = r_state;
        if (r_fsm == S_IDLE && bus.load)
            w_state_d = bus.load_val;
        else if (r_fsm == S_RUN)
            w_state_d = w_upd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_mode  <= c_mode_hold;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            case (r_fsm)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start && bus.run_len != '0) begin
                        r_cnt  <= bus.run_len;
                        r_mode <= bus.mode;
                        r_busy <= 1'b1;
                        r_fsm  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_sig  <= w_upd;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_fsm  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BENCH_SEQ_TRIG_MON_EN
    logic r_trig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_trig <= 1'b0;
        else if (w_state_d == TRIG_VAL)
            r_trig <= 1'b1;
    end

    assign bus.trig_hit = r_trig;
`else
    // TRIG_VAL stays in the parameter list so both builds share one interface.
    logic w_unused_trig_val;
    assign w_unused_trig_val = ^TRIG_VAL;
    assign bus.trig_hit      = 1'b0;
`endif

    assign bus.out       = r_state[OUT_W-1:0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.signature = r_sig;

endmodule

`default_nettype wire

// File: tb/tb_bench_seq_misr.sv
// =============================================================================
// tb_bench_seq_misr : randomized + directed bench for bench_seq_misr
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_bench_seq_misr;

    localparam int IN_W     = 9;
    localparam int STATE_W  = 15;
    localparam int OUT_W    = 11;
    localparam int CNT_W    = 8;
    localparam int POLY     = 'h0003;
    localparam int TRIG_VAL = 'h01FE;
`ifdef BENCH_SEQ_TRIG_MON_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bench_seq_misr_if #(.IN_W(IN_W), .STATE_W(STATE_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    bench_seq_misr #(.IN_W(IN_W), .STATE_W(STATE_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Update rules in plain integer arithmetic on a 15-bit value.
    function automatic int upd(input int s, input int md, input int x);
        int sh;
        sh = (s * 2) % 32768;
        case (md)
            0:       return s;
            1:       return s ^ x;
            2:       return sh ^ ((s >= 16384) ? POLY : 0) ^ x;
            default: return (sh + s / 16384) ^ x;
        endcase
    endfunction

    // Reference model: remaining updates, latched mode, state, signature.
    int m_state = 0;
    int m_sig   = 0;
    int m_left  = 0;
    int m_mode  = 0;
    int m_nxt   = 0;
    bit m_done  = 1'b0;
    bit m_trig  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_sig = 0; m_left = 0; m_mode = 0;
            m_done  = 1'b0; m_trig = 1'b0;
        end else begin
            m_nxt = m_state;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                m_nxt = upd(m_state, m_mode, int'(bus.in));
                m_left--;
                if (m_left == 0) begin
                    m_sig  = m_nxt;
                    m_done = 1'b1;
                end
            end else begin
                if (bus.load) m_nxt = int'(bus.load_val);
                if (bus.start && bus.run_len != 0) begin
                    m_left = int'(bus.run_len);
                    m_mode = int'(bus.mode);
                end
            end
            if (TRIG_EN && m_nxt == TRIG_VAL) m_trig = 1'b1;
            m_state = m_nxt;
        end
    end

    always @(negedge clk) begin
        check("mdl_out",  32'(bus.out),       32'(m_state[OUT_W-1:0]));
        check("mdl_sig",  32'(bus.signature), 32'(m_sig));
        check("mdl_busy", 32'(bus.busy),      32'(m_left > 0));
        check("mdl_done", 32'(bus.done),      32'(m_done));
        check("mdl_trig", 32'(bus.trig_hit),  32'(m_trig));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1; bus.load_val = 15'(v);
        tick();
        bus.load = 1'b0;
    endtask

    task automatic do_start(input int md, input int x, input int len);
        bus.start = 1'b1; bus.mode = 2'(md); bus.in = 9'(x); bus.run_len = 8'(len);
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.mode  = 2'b00; bus.run_len = '0; bus.in = '0;
        repeat (2) tick();
        check("rst_out",  32'(bus.out), 32'h0);
        check("rst_sig",  32'(bus.signature), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        reset = 1'b1;
        tick();

        // XOR run of 3 from 0001
        do_load('h0001);
        check("s1_load", 32'(bus.out), 32'h001);
        do_start(1, 'h1FF, 3);
        check("s1_busy0", 32'(bus.busy), 32'h1);
        tick();
        check("s1_u1",    32'(bus.out), 32'h1FE);
        check("s1_trig",  32'(bus.trig_hit), 32'(TRIG_EN));
        check("s1_busy1", 32'(bus.busy), 32'h1);
        tick();
        check("s1_u2",    32'(bus.out), 32'h001);
        check("s1_busy2", 32'(bus.busy), 32'h1);
        tick();
        check("s1_u3",    32'(bus.out), 32'h1FE);
        check("s1_busy3", 32'(bus.busy), 32'h0);
        check("s1_done",  32'(bus.done), 32'h1);
        check("s1_sig",   32'(bus.signature), 32'h01FE);
        tick();
        check("s1_done_off", 32'(bus.done), 32'h0);
        check("s1_trig_stk", 32'(bus.trig_hit), 32'(TRIG_EN));

        // MISR runs
        do_load('h4000);
        do_start(2, 0, 1);
        tick();
        check("s2_u1",  32'(bus.out), 32'h003);
        check("s2_sig", 32'(bus.signature), 32'h0003);
        check("s2_done", 32'(bus.done), 32'h1);
        tick();
        do_load('h4001);
        do_start(2, 0, 2);
        tick();
        check("s2b_u1", 32'(bus.out), 32'h001);
        tick();
        check("s2b_u2", 32'(bus.out), 32'h002);
        check("s2b_sig", 32'(bus.signature), 32'h0002);
        tick();

        // ROT run
        do_load('h4001);
        do_start(3, 0, 2);
        tick();
        check("s3_u1", 32'(bus.out), 32'h003);
        check("s3_done_early", 32'(bus.done), 32'h0);
        tick();
        check("s3_u2", 32'(bus.out), 32'h006);
        check("s3_done", 32'(bus.done), 32'h1);
        tick();

        // Handshake edges
        do_start(1, 5, 0);
        check("s4_len0", 32'(bus.busy), 32'h0);
        do_start(1, 5, 3);
        bus.start = 1'b1; bus.run_len = 8'd7; bus.mode = 2'b10;
        bus.load = 1'b1; bus.load_val = 15'h7FFF;
        tick();
        bus.start = 1'b0; bus.load = 1'b0;
        tick();
        tick();
        check("s4_ign_sig",  32'(bus.signature), 32'h0003);
        check("s4_ign_done", 32'(bus.done), 32'h1);
        tick();
        check("s4_ign_busy", 32'(bus.busy), 32'h0);
        bus.load = 1'b1; bus.load_val = 15'h0010;
        do_start(1, 1, 1);
        bus.load = 1'b0;
        tick();
        check("s4_ls_sig", 32'(bus.signature), 32'h0011);
        tick();

        // Reset mid-run
        do_start(1, 1, 5);
        tick();
        reset = 1'b0;
        #1;
        check("s5_out",  32'(bus.out), 32'h0);
        check("s5_sig",  32'(bus.signature), 32'h0);
        check("s5_busy", 32'(bus.busy), 32'h0);
        check("s5_done", 32'(bus.done), 32'h0);
        check("s5_trig", 32'(bus.trig_hit), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        do_load('h0003);
        do_start(1, 1, 2);
        tick();
        tick();
        check("s5_rerun_sig", 32'(bus.signature), 32'h0003);
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.load     = ($urandom_range(0, 3) == 0);
            bus.load_val = ($urandom_range(0, 9) == 0) ? 15'(TRIG_VAL) : 15'($urandom);
            bus.mode     = 2'($urandom);
            bus.run_len  = 8'($urandom_range(0, 6));
            bus.in       = 9'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        bus.start = 1'b0; bus.load = 1'b0;
        repeat (10) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bench_seq_misr.md
Name: bench_seq_misr

Overview:
Parametrised next-generation sequential benchmark core: an N-bit state register with selectable update mode (hold, XOR-accumulate, MISR compaction, rotate-XOR). Each run lasts a programmed number of cycles and is framed by a start/busy/done handshake. The final state is captured as a signature. It is a configurable sequential test article for the benchmark suite, and its default sizing matches the existing 9-in / 15-state / 11-out generic circuit.

Parameters:
IN_W, 9, input data width
STATE_W, 15, state register width; must be >= 2
OUT_W, 11, output slice width; must be <= STATE_W (elaboration error otherwise)
CNT_W, 8, run-length counter width
POLY, 15'h0003, MISR feedback mask of STATE_W bits, XORed in when the shifted-out MSB is 1
TRIG_VAL, 15'h01FE, trigger compare value of STATE_W bits; used only with the optional feature

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  run request; sampled only in IDLE
load  input  1  state preload strobe; honoured only in IDLE
load_val  input  STATE_W  preload value
mode  input  2  update mode: 00 HOLD, 01 XOR, 10 MISR, 11 ROT
run_len  input  CNT_W  number of update cycles; sampled together with start
in  input  IN_W  data input
out  output  OUT_W  state[OUT_W-1:0], continuous
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE
signature  output  STATE_W  registered final state of the last run
trig_hit  output  1  sticky trigger flag; tied 0 without the macro

Behaviour:
- Reset is asynchronous and active-low (reset = 0). Clock is clk. On reset, state, signature, counter and trig_hit go to 0, FSM goes to IDLE, and busy = done = 0.
- Width rule for `in`: zero-extended to STATE_W if IN_W < STATE_W; truncated to the low STATE_W bits if IN_W > STATE_W. Call the result inx.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load = 1 -> state <= load_val.
  - start = 1 and run_len != 0 -> counter <= run_len, mode latched, enter RUN.
  - start with run_len == 0 is ignored and the FSM stays in IDLE.
  - load and start in the same cycle: both are honoured, and the first RUN update operates on load_val.
- RUN: on each clock edge state <= f(state) and counter decrements. In RUN, `mode` is the latched copy taken at start (input changes mid-run are ignored). Update functions:
  - HOLD: state.
  - XOR: state ^ inx.
  - MISR: {state[STATE_W-2:0],1'b0} ^ (state[STATE_W-1] ? POLY : 0) ^ inx.
  - ROT: {state[STATE_W-2:0], state[STATE_W-1]} ^ inx.
- RUN exit: on the edge where counter == 1, the final update is applied, signature <= the updated value, and the FSM enters DONE. Exactly run_len updates occur, and busy is high for exactly run_len cycles.
- DONE: done = 1 for one cycle, then IDLE unconditionally. State is held; start and load are ignored.
- start while busy is ignored; load in RUN or DONE is ignored.
- Reset asserted mid-run aborts the run immediately: all registers return to their reset values and no done pulse is generated.
- Latency: start edge -> busy on the next cycle; done asserts in the cycle after the final update.
- out follows state with no added latency; signature holds until the next run completes.

Optional Feature:
Macro BENCH_SEQ_TRIG_MON_EN.
- Defined: compare logic sets trig_hit <= 1 on any edge where the next state equals TRIG_VAL. trig_hit is sticky and cleared only by reset.
- Undefined: no compare logic is built and trig_hit is constant 0. The port list is identical in both builds.

Test Plan:
1. XOR mode, defaults: load 15'h0001, then start with mode 01, in 9'h1FF, run_len 3 -> state steps 01FE, 0001, 01FE. busy is high for 3 cycles, done pulses once, signature = 15'h01FE, out = 11'h1FE.
2. MISR mode: load 15'h4000, mode 10, in 0, run_len 1 -> state = 15'h0003 and signature = 15'h0003. Then rerun with run_len 2 from 15'h4001 -> steps 0x0001, 0x0002.
3. ROT mode: load 15'h4001, mode 11, in 0, run_len 2 -> steps 15'h0003, 15'h0006; done pulses after the 2nd update.
4. Handshake edges: start with run_len 0 -> no busy. start again while busy -> ignored. load during RUN -> state unaffected. load+start in the same cycle with load_val 15'h0010, XOR, in 9'h001, run_len 1 -> signature 15'h0011.
5. Reset mid-run: assert reset at the 2nd cycle of a 5-cycle XOR run -> state, signature, busy and done are 0 immediately; no done pulse; the next run behaves normally.
6. With BENCH_SEQ_TRIG_MON_EN: rerun scenario 1 -> trig_hit rises on the first update to 01FE and stays 1 until reset. Without the macro, trig_hit stays 0.
